// File: rtl/train_transit_timer.sv
// train_transit_timer: measures the S1 -> S2 transit time of a train in ms.
// Sensors are synchronised, optionally debounced, and edge detected. A
// two-state FSM (IDLE / MEASURE) runs a prescaled ms counter between the
// s1 and s2 events. It reports either a time_valid pulse with time_in
// loaded, or a timeout pulse when the count reaches MAX_MS.
// Optional feature macro: SENSOR_DEBOUNCE_EN (per-sensor stable-level filter).
//
// Output handshake: time_valid is a one-cycle strobe with no ready. time_in
// is valid in the strobe cycle and holds until the next strobe. timeout is
// a one-cycle strobe, exclusive with time_valid. busy mirrors the FSM state
// (1 = MEASURE) and is the debug view of the state register.
module train_transit_timer #(
  parameter int TICK_DIV   = 50000,
  parameter int MAX_MS     = 524287,
  parameter int DEB_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s1,
  input  logic        s2,
  output logic [18:0] time_in,
  output logic        time_valid,
  output logic        timeout,
  output logic        busy
);

  localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PSW-1:0] PRESC_LAST = PSW'(TICK_DIV - 1);
  localparam logic [18:0]    MAX_V      = 19'(MAX_MS);

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [PSW-1:0]   presc_q, presc_d;
  logic [18:0]      ms_q, ms_d, ms_next;
  logic             tick, load, abort;

  // Bit 0 carries s1, bit 1 carries s2 throughout the sensor path.
  logic [1:0]       meta_q, sync_q, lvl, lvl_prev_q, armed_q, ev;
  logic [1:0]       prime_q;
  logic             primed;

  // Two-flop synchronisers for both sensors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 2'b00;
      sync_q <= 2'b00;
    end else begin
      meta_q <= {s2, s1};
      sync_q <= meta_q;
    end
  end

  // Priming counter: sync_q only reflects the real pins two cycles after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prime_q <= 2'd0;
    else if (prime_q != 2'd2) prime_q <= prime_q + 2'd1;
  end
  assign primed = (prime_q == 2'd2);

  // Arm each sensor only once it has been seen low after reset, so a pin
  // already high when reset releases cannot produce a spurious event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed_q <= 2'b00;
    else        armed_q <= armed_q | ({2{primed}} & ~sync_q);
  end

`ifdef SENSOR_DEBOUNCE_EN
  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);

  logic [1:0] filt_q;

  for (genvar g = 0; g < 2; g++) begin : g_deb
    logic [DCW-1:0] cnt_q;
    // Filtered level follows sync only after DEB_CYCLES consecutive cycles
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q     <= '0;
        filt_q[g] <= 1'b0;
      end else if (sync_q[g] == filt_q[g]) begin
        cnt_q     <= '0;
      end else if (cnt_q == DEB_LAST) begin
        cnt_q     <= '0;
        filt_q[g] <= sync_q[g];
      end else begin
        cnt_q     <= cnt_q + 1'b1;
      end
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_q;
`endif

  // Previous level register for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_prev_q <= 2'b00;
    else        lvl_prev_q <= lvl;
  end

  assign ev = lvl & ~lvl_prev_q & armed_q;

  // Tick on the last prescaler count; the counter value seen by a
  // same-cycle s2 event includes this tick
  assign tick    = (state_q == MEASURE) && (presc_q == PRESC_LAST);
  assign ms_next = ms_q + {18'd0, tick};

  // Next-state and counter logic; s2 beats s1 beats timeout in MEASURE
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    ms_d    = ms_q;
    load    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        ms_d    = '0;
        if (ev[0]) state_d = MEASURE;
      end
      MEASURE: begin
        if (ev[1]) begin
          load    = 1'b1;
          state_d = IDLE;
          presc_d = '0;
          ms_d    = '0;
        end else if (ev[0]) begin
          presc_d = '0;
          ms_d    = '0;
        end else if (ms_next == MAX_V) begin
          abort   = 1'b1;
          state_d = IDLE;
          presc_d = '0;
          ms_d    = '0;
        end else begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          ms_d    = ms_next;
        end
      end
      default: begin
        state_d = IDLE;
        presc_d = '0;
        ms_d    = '0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      ms_q       <= '0;
      time_in    <= '0;
      time_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      ms_q       <= ms_d;
      time_valid <= load;
      timeout    <= abort;
      if (load) time_in <= ms_next;
    end
  end

  assign busy = (state_q == MEASURE);

endmodule

// File: tb/tb_train_transit_timer.sv
// Directed bench for train_transit_timer with TICK_DIV = 4, MAX_MS = 12.
// Build with +define+SENSOR_DEBOUNCE_EN to exercise the debounce variant.
module tb_train_transit_timer;

  localparam int TICK_DIV = 4;
  localparam int MAX_MS   = 12;
  localparam int DEB      = 4;
`ifdef SENSOR_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
  localparam int PW  = DEB + 2;
`else
  localparam int LAT = 3;
  localparam int PW  = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s1 = 1'b0;
  logic        s2 = 1'b0;
  logic        s1_hold = 1'b0;
  logic [18:0] time_in;
  logic        time_valid;
  logic        timeout;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt = 0;
  int tcnt = 0;
  int both = 0;
  logic busy_h [0:127];
  logic busy_any;

  typedef struct {
    int gap;
    int exp_time;
    int exp_valid;
    int exp_to;
  } vec_t;
  vec_t vecs [11];

  // Clock
  always #5 clk = ~clk;

  train_transit_timer #(
    .TICK_DIV  (TICK_DIV),
    .MAX_MS    (MAX_MS),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s1        (s1),
    .s2        (s2),
    .time_in   (time_in),
    .time_valid(time_valid),
    .timeout   (timeout),
    .busy      (busy)
  );

  // Pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (time_valid) vcnt++;
    if (timeout) tcnt++;
    if (time_valid && timeout) both++;
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive n cycles; s1 pulses start at a0/a1, s2 at b0 (-1 = none), width pw
  task automatic run(input int a0, input int a1, input int b0, input int pw, input int n);
    busy_any = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s1 = s1_hold | (a0 >= 0 && i >= a0 && i < a0 + pw) | (a1 >= 0 && i >= a1 && i < a1 + pw);
      s2 = (b0 >= 0 && i >= b0 && i < b0 + pw);
      if (i < 128) busy_h[i] = busy;
      if (busy) busy_any = 1'b1;
    end
    s1 = s1_hold;
    s2 = 1'b0;
  endtask

  initial begin
    int v0;
    int t0;

    // gap = cycles from s1 pin rise to s2 pin rise; time = floor(gap / 4)
    vecs[0]  = '{40, 10, 1, 0};
    vecs[1]  = '{1,  0,  1, 0};
    vecs[2]  = '{3,  0,  1, 0};
    vecs[3]  = '{4,  1,  1, 0};
    vecs[4]  = '{7,  1,  1, 0};
    vecs[5]  = '{8,  2,  1, 0};
    vecs[6]  = '{48, 12, 1, 0};
    vecs[7]  = '{47, 11, 1, 0};
    vecs[8]  = '{0,  11, 0, 1};
    vecs[9]  = '{49, 11, 0, 1};
    vecs[10] = '{20, 5,  1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_time_in", int'(time_in), 0);
    check("rst_valid", int'(time_valid), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Table-driven transits
    for (int k = 0; k < 11; k++) begin
      v0 = vcnt;
      t0 = tcnt;
      run(0, -1, vecs[k].gap, PW, vecs[k].gap + 60);
      check($sformatf("vec%0d_time_in", k), int'(time_in), vecs[k].exp_time);
      check($sformatf("vec%0d_valid_cnt", k), vcnt - v0, vecs[k].exp_valid);
      check($sformatf("vec%0d_timeout_cnt", k), tcnt - t0, vecs[k].exp_to);
      check($sformatf("vec%0d_busy_end", k), int'(busy), 0);
    end

    // s2 alone in IDLE does nothing
    v0 = vcnt;
    t0 = tcnt;
    run(-1, -1, 0, PW, 20);
    check("s2_idle_busy", int'(busy_any), 0);
    check("s2_idle_valid", vcnt - v0, 0);
    check("s2_idle_timeout", tcnt - t0, 0);

    // s1 and s2 together from IDLE: s1 wins, then times out
    run(0, -1, 0, PW, 60);
    check("simul_busy_pre", int'(busy_h[LAT-1]), 0);
    check("simul_busy_lat", int'(busy_h[LAT]), 1);
    check("simul_valid", vcnt - v0, 0);
    check("simul_timeout", tcnt - t0, 1);

    // Restart: s1, 5 ticks, s1 again, 3 ticks, s2
    v0 = vcnt;
    t0 = tcnt;
    run(0, 20, 32, PW, 50);
    check("restart_busy_held", int'(busy_h[20+LAT+1]), 1);
    check("restart_busy_last", int'(busy_h[32+LAT-1]), 1);
    check("restart_busy_done", int'(busy_h[32+LAT]), 0);
    check("restart_time_in", int'(time_in), 3);
    check("restart_valid", vcnt - v0, 1);
    check("restart_timeout", tcnt - t0, 0);

    // Mid-measurement asynchronous reset with s1 held high through release
    run(0, -1, -1, PW, LAT + 25);
    check("pre_rst_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    s1_hold = 1'b1;
    s1 = 1'b1;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_time_in", int'(time_in), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v0 = vcnt;
    run(-1, -1, 5, PW, 30);
    check("held_s1_busy", int'(busy_any), 0);
    check("post_rst_s2_valid", vcnt - v0, 0);
    s1_hold = 1'b0;
    run(-1, -1, -1, PW, 20);
    run(0, -1, -1, PW, LAT + 2);
    check("rearm_busy", int'(busy_h[LAT]), 1);
    v0 = vcnt;
    run(-1, -1, 0, PW, LAT + 4);
    check("rearm_valid", vcnt - v0, 1);
    check("rearm_time_in", int'(time_in), (LAT + 2) / TICK_DIV);

`ifdef SENSOR_DEBOUNCE_EN
    // Short glitch is filtered; 6-cycle pulse is accepted after 7 cycles
    run(0, -1, -1, 2, 20);
    check("deb_glitch_busy", int'(busy_any), 0);
    run(0, -1, -1, 6, 10);
    check("deb_busy_6", int'(busy_h[6]), 0);
    check("deb_busy_7", int'(busy_h[7]), 1);
    run(-1, -1, -1, PW, 60);
    check("deb_busy_end", int'(busy), 0);
`endif

    check("valid_and_timeout_overlap", both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/train_transit_timer.md
TRAIN_TRANSIT_TIMER -- requirements
Module: train_transit_timer

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 50000, clk cycles per 1 ms tick (50 MHz clk).
REQ-002 SHALL provide parameter MAX_MS, default 524287, the ms count at which a measurement is aborted (≤ 2^19-1).
REQ-003 SHALL provide parameter DEB_CYCLES, default 16, the stable-cycle count for the sensor debounce filter.
REQ-004 SHALL have port clk input 1: the single clock; all state is clocked on posedge clk.
REQ-005 SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-006 SHALL have port s1 input 1: track sensor 1, asynchronous, active-high.
REQ-007 SHALL have port s2 input 1: track sensor 2, asynchronous, active-high.
REQ-008 SHALL have port time_in output 19: last measured S1→S2 transit time in ms, the value consumed by the predictor.
REQ-009 SHALL have port time_valid output 1: one-cycle pulse when time_in is updated.
REQ-010 SHALL have port timeout output 1: one-cycle pulse when a measurement aborts at MAX_MS.
REQ-011 SHALL have port busy output 1: high while a measurement is in progress.

Function
REQ-012 SHALL synchronise s1 and s2 each through two flops, then rising-edge detect; an event is seen 3 cycles after the pin rises (DEBOUNCE_EN absent).
REQ-013 SHALL implement FSM states IDLE and MEASURE; busy = (state == MEASURE).
REQ-014 In IDLE, an s1 event SHALL enter MEASURE with ms counter = 0 and prescaler = 0; an s2 event SHALL be ignored.
REQ-015 In MEASURE, the prescaler SHALL count 0..TICK_DIV-1 and wrap, asserting a tick on the cycle it equals TICK_DIV-1; the 19-bit ms counter SHALL increment on each tick.
REQ-016 In MEASURE, an s2 event SHALL load time_in with the ms counter value including any tick in that same cycle, pulse time_valid for exactly one cycle the next cycle, and return to IDLE.
REQ-017 An s2 event before the first tick SHALL report time_in = 0 with time_valid.
REQ-018 In MEASURE, an s1 event without s2 SHALL restart: ms counter and prescaler cleared, remain in MEASURE, no output pulse.
REQ-019 Simultaneous s1 and s2 events: in IDLE, s1 wins (enter MEASURE); in MEASURE, s2 wins (measurement completes).
REQ-020 When the ms counter reaches MAX_MS with no s2 event, the block SHALL pulse timeout for one cycle, leave time_in unchanged, and return to IDLE; s2 in the same cycle takes priority (valid result = MAX_MS).
REQ-021 time_in SHALL hold its value between updates; time_valid and timeout SHALL never both be high.
REQ-022 Prescaler and counter SHALL be held at zero in IDLE.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, time_in = 0, time_valid = 0, timeout = 0, busy = 0, counters, synchronisers, edge detectors and debounce filters cleared, including mid-measurement.
REQ-024 After rst_n rises, a sensor input already high SHALL NOT produce an event until it goes low and high again.

Configuration
REQ-025 Macro SENSOR_DEBOUNCE_EN defined: each synchronised sensor SHALL pass a filter whose output changes only after the input has held the new level for DEB_CYCLES consecutive cycles; edge detection uses the filtered level; event latency becomes 3 + DEB_CYCLES cycles.
REQ-026 Macro SENSOR_DEBOUNCE_EN undefined: the filter SHALL be absent, DEB_CYCLES unused, latency per REQ-012.

Verification (TICK_DIV = 4 unless stated)
REQ-027 s1 pulse, 40 cycles later s2 pulse → single time_valid pulse, time_in = 10, busy falls.
REQ-028 MAX_MS = 8, s1 pulse, no s2 → timeout pulse after 8 ticks (32 cycles), time_valid never asserted, time_in unchanged, busy = 0.
REQ-029 s2 pulse in IDLE → no output activity; then s1 and s2 rising in the same cycle → busy = 1, no time_valid.
REQ-030 s1, 5 ticks, s1 again, 3 ticks, s2 → time_in = 3, exactly one time_valid.
REQ-031 s1, 6 ticks, rst_n low 2 cycles → busy = 0 and time_in = 0 asynchronously; a later s2 alone produces no time_valid.
REQ-032 SENSOR_DEBOUNCE_EN, DEB_CYCLES = 4: 2-cycle glitch on s1 → no busy; 6-cycle s1 pulse → busy rises 7 cycles after the pin.
